sampler_multi: RTL and testbench
================================

# sampler_multi

Parametrised successor to the 16-channel event sampler, inside the muon DAQ acquisition chain. Continuously deserialises N_CH asynchronous pulse lines into a WINDOW-deep per-channel history. On an external or self-generated (channel-coincidence) trigger it freezes a window with a programmable pre-/post-trigger split. It presents the window to the readout side through a 4-phase ready/saved handshake and counts triggers lost while busy.

## Interface
- N_CH, 16: number of channels.
- WINDOW, 64: samples per channel per event, at least 2.
- POST_TRIG, 32: samples captured after the trigger-accept edge, 0..WINDOW-1.
- clk  in  1  sampling clock, 100 MHz.
- aresetn  in  1  asynchronous, active-low reset.
- ch_in  in  N_CH  single-ended, asynchronous channel pulses, already buffered at top level.
- trig_tresh  in  1  asynchronous external trigger, rising edge.
- trig_mode  in  2  0 external, 1 self, 2 either, 3 disabled; quasi-static.
- coinc_thresh  in  $clog2(N_CH+1)  minimum active channels for a self trigger; 0 disables self trigger.
- event_saved  in  1  asynchronous readout acknowledge.
- event_ready  out  1  event valid.
- evento  out  N_CH×WINDOW  packed [N_CH-1:0][WINDOW-1:0]; bit 0 is the oldest sample.
- event_id  out  16  number of the presented event.
- missed_cnt  out  16  saturating count of triggers rejected while busy.

## Operation
- Channel path: 2-FF synchroniser, then 1 pipeline register, then shift into bit WINDOW-1; each channel shifts toward bit 0 every cycle.
- External path: 2-FF synchroniser, then rising-edge detect.
- Self path: popcount of the pipeline-register vector; the trigger is the rising edge of (popcount ≥ coinc_thresh).
- event_saved passes through a 2-FF synchroniser.
- Fill guard: a counter saturates at WINDOW after reset. Triggers before saturation are ignored and are not counted as missed.
- FSM IDLE → POST → READY → RELEASE → IDLE:
  - IDLE: a qualified trigger moves to POST and loads post_cnt = POST_TRIG. The edge that leaves IDLE is the trigger-accept edge E0.
  - POST: post_cnt decrements each cycle. At post_cnt == 0 the next edge latches evento, sets event_ready and moves to READY.
  - READY: event_ready = 1, evento held. When synced event_saved is 1, the next edge clears event_ready and moves to RELEASE.
  - RELEASE: waits for synced event_saved = 0, then moves to IDLE and increments event_id (wraps at 0xFFFF → 0).
- A qualified trigger seen in POST, READY or RELEASE increments missed_cnt, saturating at 0xFFFF.
- Simultaneous external and self trigger in mode 2 counts as one trigger.
- Missed triggers are never queued.

## Timing
- Reset values: event_ready 0, evento 0, event_id 0, missed_cnt 0, state IDLE, shift registers 0, fill counter 0.
- Reset mid-event aborts with no partial event.
- Channel latency: an input sampled at edge e reaches bit WINDOW-1 at edge e+3.
- External trigger sampled at edge e is accepted at E0 = e+2.
- Self trigger: its triggering vector enters bit WINDOW-1 at E0.
- The sample shifted in at E0 sits at bit WINDOW-1-POST_TRIG of evento.
- The capture edge is E0+POST_TRIG+1; event_ready rises on that same edge.
- POST_TRIG = 0: capture at E0+1, and the trigger sample lands at bit WINDOW-1.
- event_saved-to-event_ready-low latency: 3 edges (2 sync + 1).
- Minimum spacing between accepted triggers: POST_TRIG+1 cycles plus handshake time plus 1 IDLE cycle.
- evento is stable for the whole time event_ready = 1.

## Configuration
- SAMPLER_TIMESTAMP_EN defined:
  - Adds output timestamp [31:0], a free-running counter from reset (wrapping) latched on the capture edge.
  - Reset value 0; held in READY and RELEASE.
- Macro undefined: no timestamp port and no counter logic.

## Test plan
- Reset, then trig_tresh pulse before WINDOW cycles have elapsed → no event, missed_cnt = 0.
- N_CH=16, WINDOW=64, POST_TRIG=32, mode 0; ch_in[3] high for exactly the input edge that samples the trig_tresh rise → event_ready at E0+33; evento[3] has a single 1 at bit 32 and all other channels are 0.
- Mode 1, coinc_thresh = 3; channels 0,1,2 pulsed together for one cycle → event whose bit 31 is set on channels 0-2; event_id reads 0, then 1 after the handshake.
- While in READY, five more external triggers → missed_cnt = 5. Hold event_saved high, then low → IDLE, event_id = 1.
- POST_TRIG = 0, mode 2, external and self triggers on the same cycle → exactly one event, trigger sample at bit 63, missed_cnt = 0.
- aresetn low while in POST → all outputs 0 at once; the next event after refill is captured normally.

Source files
------------

// File: rtl/sampler_multi_if.sv
// Bundle of the sampler's channel, trigger, readout-handshake and debug signals.
// Optional timestamp field exists only when SAMPLER_TIMESTAMP_EN is defined.
interface sampler_multi_if #(
    parameter int N_CH   = 16,
    parameter int WINDOW = 64
);
    localparam int CW = $clog2(N_CH + 1);

    logic [N_CH-1:0]             ch_in;
    logic                        trig_tresh;
    logic [1:0]                  trig_mode;
    logic [CW-1:0]               coinc_thresh;
    logic                        event_saved;
    logic                        event_ready;
    logic [N_CH-1:0][WINDOW-1:0] evento;
    logic [15:0]                 event_id;
    logic [15:0]                 missed_cnt;
    logic [1:0]                  fsm_state;
`ifdef SAMPLER_TIMESTAMP_EN
    logic [31:0]                 timestamp;
`endif

    // Handshake: event_ready rises with a frozen evento and stays high until
    // event_saved is seen high; the next event is only possible after
    // event_saved has been seen low again (4-phase ready/saved).
    modport master (
        output ch_in, trig_tresh, trig_mode, coinc_thresh, event_saved,
        input  event_ready, evento, event_id, missed_cnt, fsm_state
`ifdef SAMPLER_TIMESTAMP_EN
        , input timestamp
`endif
    );

    modport slave (
        input  ch_in, trig_tresh, trig_mode, coinc_thresh, event_saved,
        output event_ready, evento, event_id, missed_cnt, fsm_state
`ifdef SAMPLER_TIMESTAMP_EN
        , output timestamp
`endif
    );
endinterface

// File: rtl/sampler_multi.sv
// Multi-channel event sampler: per-channel WINDOW-deep history frozen on external or
// coincidence trigger with pre/post split. SAMPLER_TIMESTAMP_EN adds a capture timestamp.
module sampler_multi #(
    parameter int N_CH      = 16,
    parameter int WINDOW    = 64,
    parameter int POST_TRIG = 32
) (
    input logic           clk,
    input logic           aresetn,
    sampler_multi_if.slave bus
);
    localparam int CW = $clog2(N_CH + 1);
    localparam int FW = $clog2(WINDOW + 1);
    localparam int PW = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
    localparam logic [FW-1:0] FILL_FULL = FW'(WINDOW);
    localparam logic [PW-1:0] POST_LOAD = PW'(POST_TRIG);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_POST    = 2'd1,
        S_READY   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    logic [N_CH-1:0]             ch_s1_q, ch_s2_q, ch_pipe_q;
    logic [N_CH-1:0][WINDOW-1:0] shift_q, shift_d;
    logic                        ext_s1_q, ext_s2_q, ext_prev_q;
    logic                        sav_s1_q, sav_s2_q;
    logic                        coinc_prev_q;
    logic [FW-1:0]               fill_q;
    state_t                      state_q, state_d;
    logic [PW-1:0]               post_q, post_d;
    logic                        ready_q, ready_d;
    logic [N_CH-1:0][WINDOW-1:0] evento_q, evento_d;
    logic [15:0]                 id_q, id_d;
    logic [15:0]                 missed_q, missed_d;

    logic [CW-1:0] pop;
    logic          coinc_now, ext_rise, self_rise, trig_any, trig_ok;
    logic          capture, missed_inc;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            pop = pop + CW'(ch_pipe_q[i]);
        end
    end

    assign coinc_now = (bus.coinc_thresh != '0) && (pop >= bus.coinc_thresh);
    assign ext_rise  = ext_s2_q & ~ext_prev_q;
    assign self_rise = coinc_now & ~coinc_prev_q;

    // Mode 2 ORs the sources so a coincident external+self trigger counts once.
    always_comb begin
        case (bus.trig_mode)
            2'd0:    trig_any = ext_rise;
            2'd1:    trig_any = self_rise;
            2'd2:    trig_any = ext_rise | self_rise;
            default: trig_any = 1'b0;
        endcase
    end

    // Triggers are meaningless until the history has been completely filled.
    assign trig_ok = trig_any && (fill_q == FILL_FULL);
    assign capture = (state_q == S_POST) && (post_q == '0);

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            shift_d[c] = {ch_pipe_q[c], shift_q[c][WINDOW-1:1]};
        end
    end

    always_comb begin
        state_d    = state_q;
        post_d     = post_q;
        ready_d    = ready_q;
        evento_d   = evento_q;
        id_d       = id_q;
        missed_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig_ok) begin
                    state_d = S_POST;
                    post_d  = POST_LOAD;
                end
            end
            S_POST: begin
                missed_inc = trig_ok;
                if (capture) begin
                    state_d  = S_READY;
                    ready_d  = 1'b1;
                    evento_d = shift_q;
                end else begin
                    post_d = post_q - 1'b1;
                end
            end
            S_READY: begin
                missed_inc = trig_ok;
                if (sav_s2_q) begin
                    state_d = S_RELEASE;
                    ready_d = 1'b0;
                end
            end
            S_RELEASE: begin
                missed_inc = trig_ok;
                if (!sav_s2_q) begin
                    state_d = S_IDLE;
                    id_d    = id_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        missed_d = (missed_inc && (missed_q != 16'hFFFF)) ? missed_q + 16'd1 : missed_q;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ch_s1_q      <= '0;
            ch_s2_q      <= '0;
            ch_pipe_q    <= '0;
            shift_q      <= '0;
            ext_s1_q     <= 1'b0;
            ext_s2_q     <= 1'b0;
            ext_prev_q   <= 1'b0;
            sav_s1_q     <= 1'b0;
            sav_s2_q     <= 1'b0;
            coinc_prev_q <= 1'b0;
            fill_q       <= '0;
            state_q      <= S_IDLE;
            post_q       <= '0;
            ready_q      <= 1'b0;
            evento_q     <= '0;
            id_q         <= '0;
            missed_q     <= '0;
        end else begin
            ch_s1_q      <= bus.ch_in;
            ch_s2_q      <= ch_s1_q;
            ch_pipe_q    <= ch_s2_q;
            shift_q      <= shift_d;
            ext_s1_q     <= bus.trig_tresh;
            ext_s2_q     <= ext_s1_q;
            ext_prev_q   <= ext_s2_q;
            sav_s1_q     <= bus.event_saved;
            sav_s2_q     <= sav_s1_q;
            coinc_prev_q <= coinc_now;
            if (fill_q != FILL_FULL) fill_q <= fill_q + 1'b1;
            state_q      <= state_d;
            post_q       <= post_d;
            ready_q      <= ready_d;
            evento_q     <= evento_d;
            id_q         <= id_d;
            missed_q     <= missed_d;
        end
    end

`ifdef SAMPLER_TIMESTAMP_EN
    logic [31:0] ts_cnt_q, ts_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            if (capture) ts_q <= ts_cnt_q;
        end
    end

    assign bus.timestamp = ts_q;
`endif

    assign bus.event_ready = ready_q;
    assign bus.evento      = evento_q;
    assign bus.event_id    = id_q;
    assign bus.missed_cnt  = missed_q;
    assign bus.fsm_state   = state_q;
endmodule

// File: tb/tb_sampler_multi.sv
// Directed bench for sampler_multi: POST_TRIG=32 and POST_TRIG=0 instances with
// queued expected events checked by per-instance monitors.
module tb_sampler_multi;
  localparam int N_CH = 16;
  localparam int WINDOW = 64;
  localparam int EVW = N_CH * WINDOW;
  localparam int EW = 32 + 16 + EVW;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  int unsigned cyc = 0;
  int n_total = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sampler_multi_if #(.N_CH(N_CH), .WINDOW(WINDOW)) bus_a ();
  sampler_multi_if #(.N_CH(N_CH), .WINDOW(WINDOW)) bus_b ();

  sampler_multi #(.N_CH(N_CH), .WINDOW(WINDOW), .POST_TRIG(32)) dut_a (
    .clk(clk), .aresetn(aresetn), .bus(bus_a)
  );
  sampler_multi #(.N_CH(N_CH), .WINDOW(WINDOW), .POST_TRIG(0)) dut_b (
    .clk(clk), .aresetn(aresetn), .bus(bus_b)
  );

  logic [EW-1:0] exp_a[$];
  logic [EW-1:0] exp_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_ev(input string name, input logic [EVW-1:0] act, input logic [EVW-1:0] exp);
    int bad;
    bad = -1;
    for (int c = N_CH - 1; c >= 0; c--)
      if (act[c*WINDOW +: WINDOW] !== exp[c*WINDOW +: WINDOW]) bad = c;
    n_total++;
    if (bad < 0) n_pass++;
    else $display("FAIL %s: channel %0d got %h, expected %h", name, bad,
                  act[bad*WINDOW +: WINDOW], exp[bad*WINDOW +: WINDOW]);
  endtask

  function automatic logic [EVW-1:0] mk_ev(input logic [N_CH-1:0] chans, input int pos);
    logic [EVW-1:0] ev;
    ev = '0;
    for (int c = 0; c < N_CH; c++)
      if (chans[c]) ev[c*WINDOW + pos] = 1'b1;
    return ev;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int which);
    return (which == 0) ? bus_a.event_ready : bus_b.event_ready;
  endfunction

  task automatic set_saved(input int which, input logic v);
    if (which == 0) bus_a.event_saved = v;
    else bus_b.event_saved = v;
  endtask

  task automatic wait_ready(input int which, input logic lvl, input int budget, input string name);
    for (int i = 0; i < budget && rdy(which) !== lvl; i++) step(1);
    chk(name, rdy(which), lvl);
  endtask

  task automatic handshake(input int which, input string name);
    wait_ready(which, 1'b1, 200, {name, "_ready"});
    set_saved(which, 1'b1);
    wait_ready(which, 1'b0, 10, {name, "_release"});
    set_saved(which, 1'b0);
    step(5);
  endtask

  // Monitors: pop one expected event on each rising event_ready.
  logic prev_a = 1'b0, prev_b = 1'b0;
  logic stable_a, stable_b;
  logic [EVW-1:0] held_a, held_b;
  logic [EW-1:0] mon_a, mon_b;

  always @(negedge clk) begin
    if (bus_a.event_ready && !prev_a) begin
      if (exp_a.size() == 0) chk("a_expected_event", exp_a.size(), 1);
      else begin
        mon_a = exp_a.pop_front();
        chk("a_ready_cycle", cyc, mon_a[EW-1 -: 32]);
        chk("a_event_id", bus_a.event_id, mon_a[EVW+15 -: 16]);
        chk_ev("a_evento", bus_a.evento, mon_a[EVW-1:0]);
      end
      held_a = bus_a.evento;
      stable_a = 1'b1;
    end else if (bus_a.event_ready) begin
      if (bus_a.evento !== held_a) stable_a = 1'b0;
    end else if (prev_a && aresetn) begin
      chk("a_evento_stable", stable_a, 1);
    end
    prev_a = bus_a.event_ready;
  end

  always @(negedge clk) begin
    if (bus_b.event_ready && !prev_b) begin
      if (exp_b.size() == 0) chk("b_expected_event", exp_b.size(), 1);
      else begin
        mon_b = exp_b.pop_front();
        chk("b_ready_cycle", cyc, mon_b[EW-1 -: 32]);
        chk("b_event_id", bus_b.event_id, mon_b[EVW+15 -: 16]);
        chk_ev("b_evento", bus_b.evento, mon_b[EVW-1:0]);
      end
      held_b = bus_b.evento;
      stable_b = 1'b1;
    end else if (bus_b.event_ready) begin
      if (bus_b.evento !== held_b) stable_b = 1'b0;
    end else if (prev_b && aresetn) begin
      chk("b_evento_stable", stable_b, 1);
    end
    prev_b = bus_b.event_ready;
  end

  initial begin
    int unsigned k;
    bus_a.ch_in = '0; bus_a.trig_tresh = 1'b0; bus_a.trig_mode = 2'd0;
    bus_a.coinc_thresh = '0; bus_a.event_saved = 1'b0;
    bus_b.ch_in = '0; bus_b.trig_tresh = 1'b0; bus_b.trig_mode = 2'd3;
    bus_b.coinc_thresh = '0; bus_b.event_saved = 1'b0;

    // Clock/reset
    aresetn = 1'b0;
    step(3);
    chk("reset_ready", bus_a.event_ready, 0);
    chk_ev("reset_evento", bus_a.evento, '0);
    chk("reset_id", bus_a.event_id, 0);
    chk("reset_missed", bus_a.missed_cnt, 0);
    chk("reset_state", bus_a.fsm_state, 0);
    aresetn = 1'b1;

    // Trigger during history fill is ignored and not counted.
    step(5);
    bus_a.trig_tresh = 1'b1;
    step(3);
    bus_a.trig_tresh = 1'b0;
    step(100);
    chk("early_missed", bus_a.missed_cnt, 0);
    chk("early_no_event", bus_a.event_ready, 0);

    // Self trigger: 3 channels for one cycle, threshold 3.
    bus_a.trig_mode = 2'd1;
    bus_a.coinc_thresh = 5'd3;
    step(1);
    bus_a.ch_in = 16'h0007;
    k = cyc;
    exp_a.push_back({k + 32'd37, 16'd0, mk_ev(16'h0007, 31)});
    step(1);
    bus_a.ch_in = '0;
    wait_ready(0, 1'b1, 100, "self_ready");

    // Five external triggers while READY are all rejected.
    bus_a.trig_mode = 2'd0;
    repeat (5) begin
      bus_a.trig_tresh = 1'b1;
      step(2);
      bus_a.trig_tresh = 1'b0;
      step(2);
    end
    step(4);
    chk("busy_missed", bus_a.missed_cnt, 5);
    chk("busy_still_ready", bus_a.event_ready, 1);
    handshake(0, "self_hs");
    chk("self_id_after", bus_a.event_id, 1);
    chk("self_state_idle", bus_a.fsm_state, 0);

    // External trigger with ch3 sampled on the same edge.
    step(80);
    bus_a.ch_in = 16'h0008;
    bus_a.trig_tresh = 1'b1;
    k = cyc;
    exp_a.push_back({k + 32'd36, 16'd1, mk_ev(16'h0008, 32)});
    step(1);
    bus_a.ch_in = '0;
    step(2);
    bus_a.trig_tresh = 1'b0;
    handshake(0, "ext_hs");
    chk("ext_id_after", bus_a.event_id, 2);
    chk("ext_missed", bus_a.missed_cnt, 5);

    // Reset while in POST aborts the event.
    step(80);
    bus_a.trig_tresh = 1'b1;
    step(11);
    bus_a.trig_tresh = 1'b0;
    chk("abort_in_post", bus_a.fsm_state, 1);
    #1;
    aresetn = 1'b0;
    #1;
    chk("abort_ready", bus_a.event_ready, 0);
    chk_ev("abort_evento", bus_a.evento, '0);
    chk("abort_id", bus_a.event_id, 0);
    chk("abort_missed", bus_a.missed_cnt, 0);
    chk("abort_state", bus_a.fsm_state, 0);
    step(2);
    aresetn = 1'b1;

    // Refill, then a normal event.
    step(80);
    bus_a.ch_in = 16'h0020;
    bus_a.trig_tresh = 1'b1;
    k = cyc;
    exp_a.push_back({k + 32'd36, 16'd0, mk_ev(16'h0020, 32)});
    step(1);
    bus_a.ch_in = '0;
    step(2);
    bus_a.trig_tresh = 1'b0;
    handshake(0, "post_reset_hs");
    chk("post_reset_id", bus_a.event_id, 1);

    // POST_TRIG=0, mode 2: self and external accepted on the same edge.
    bus_b.trig_mode = 2'd2;
    bus_b.coinc_thresh = 5'd2;
    step(2);
    bus_b.ch_in = 16'h0003;
    k = cyc;
    exp_b.push_back({k + 32'd5, 16'd0, mk_ev(16'h0003, 63)});
    step(1);
    bus_b.ch_in = '0;
    bus_b.trig_tresh = 1'b1;
    step(3);
    bus_b.trig_tresh = 1'b0;
    handshake(1, "dual_hs");
    chk("dual_missed", bus_b.missed_cnt, 0);
    chk("dual_id_after", bus_b.event_id, 1);

    step(20);
    chk("a_queue_drained", exp_a.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
